// File: rtl/fe_decode.sv
// fe_decode: unpacks a 256-bit little-endian Ed25519 encoding into five 51-bit
// limbs (each held in a 64-bit word) plus the X sign bit. The encoding is
// checked against p = 2^255-19 with a fixed five-cycle limb-serial borrow chain.
// A value in [p, 2^255) is reduced to value - p and flagged as noncanon.
// Build option: define FE_DECODE_STRICT_EN to reject non-canonical input
// instead (err=1, y_out forced to 0). Cycle timing is the same in both builds.
module fe_decode (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [255:0]      encoded,
    output logic              busy,
    output logic              ready,
    output logic [4:0][63:0]  y_out,
    output logic              x_sign,
    output logic              noncanon,
    output logic              err
);

    localparam int LIMBS  = 5;
    localparam int LIMB_W = 51;

    // p limbs: limb 0 is 2^51-19, limbs 1..4 are 2^51-1
    localparam logic [LIMB_W-1:0] P_HI = {LIMB_W{1'b1}};
    localparam logic [LIMB_W-1:0] P_LO = {LIMB_W{1'b1}} - LIMB_W'(18);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CMP,
        S_SEL,
        S_DONE
    } state_t;

    state_t                         state_reg, state_next;
    logic [255:0]                   enc_reg;
    logic [LIMBS-1:0][LIMB_W-1:0]   limb_reg;
    logic [LIMBS-1:0][LIMB_W-1:0]   d_reg;
    logic                           borrow_reg;
    logic [2:0]                     cnt_reg;

    logic [LIMB_W-1:0]              limb_cur;
    logic [LIMB_W-1:0]              p_cur;
    logic [LIMB_W:0]                diff;
    logic                           ge;
    logic [LIMB_W-1:0]              ge_mask;
    logic [LIMB_W-1:0]              keep_mask;
    logic                           err_next;
    logic [LIMBS-1:0][LIMB_W-1:0]   sel;
    logic [LIMBS-1:0][LIMB_W-1:0]   y_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the compare phase always runs all five limbs
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_LOAD;
            S_LOAD: state_next = S_CMP;
            S_CMP:  if (cnt_reg == 3'd4) state_next = S_SEL;
            S_SEL:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy  = (state_reg == S_LOAD) || (state_reg == S_CMP) || (state_reg == S_SEL);
    assign ready = (state_reg == S_DONE);

    // Pick the limb and the matching p limb for the current compare step
    always_comb begin
        limb_cur = '0;
        for (int i = 0; i < LIMBS; i++) begin
            if (cnt_reg == 3'(i)) limb_cur = limb_reg[i];
        end
        p_cur = (cnt_reg == 3'd0) ? P_LO : P_HI;
        diff  = {1'b0, limb_cur} - {1'b0, p_cur} - {{LIMB_W{1'b0}}, borrow_reg};
    end

    // A final borrow of 0 means value >= p; selection uses masks, not branches
    assign ge      = ~borrow_reg;
    assign ge_mask = {LIMB_W{ge}};

`ifdef FE_DECODE_STRICT_EN
    assign keep_mask = {LIMB_W{~ge}};
    assign err_next  = ge;
`else
    assign keep_mask = {LIMB_W{1'b1}};
    assign err_next  = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < LIMBS; gi++) begin : g_sel
            assign sel[gi]    = (d_reg[gi] & ge_mask) | (limb_reg[gi] & ~ge_mask);
            assign y_next[gi] = sel[gi] & keep_mask;
        end
    endgenerate

    // Input latch, limb split, borrow chain and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_reg    <= '0;
            limb_reg   <= '0;
            d_reg      <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= 3'd0;
            x_sign     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) enc_reg <= encoded;
                end
                S_LOAD: begin
                    for (int i = 0; i < LIMBS; i++) begin
                        limb_reg[i] <= enc_reg[LIMB_W*i +: LIMB_W];
                    end
                    x_sign     <= enc_reg[255];
                    borrow_reg <= 1'b0;
                    cnt_reg    <= 3'd0;
                end
                S_CMP: begin
                    for (int i = 0; i < LIMBS; i++) begin
                        if (cnt_reg == 3'(i)) d_reg[i] <= diff[LIMB_W-1:0];
                    end
                    borrow_reg <= diff[LIMB_W];
                    cnt_reg    <= cnt_reg + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Result registers: loaded on the S_SEL -> S_DONE edge, held until next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out    <= '0;
            noncanon <= 1'b0;
            err      <= 1'b0;
        end else if (state_reg == S_SEL) begin
            for (int i = 0; i < LIMBS; i++) begin
                y_out[i] <= {13'd0, y_next[i]};
            end
            noncanon <= ge;
            err      <= err_next;
        end
    end

endmodule

// File: tb/tb_fe_decode.sv
// Directed bench for fe_decode: reset state, canonical boundaries, the
// non-canonical range, back-to-back starts and a mid-operation reset.
module tb_fe_decode;

    localparam logic [254:0] P         = {255{1'b1}} - 255'd18;
    localparam logic [63:0]  LIMB_ONES = 64'h0007_FFFF_FFFF_FFFF;
    localparam logic [63:0]  LIMB_PM1  = 64'h0007_FFFF_FFFF_FFEC;

`ifdef FE_DECODE_STRICT_EN
    localparam logic         EXP_ERR_NC = 1'b1;
    localparam logic [63:0]  EXP_Y0_MAX = 64'd0;
`else
    localparam logic         EXP_ERR_NC = 1'b0;
    localparam logic [63:0]  EXP_Y0_MAX = 64'd18;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [255:0]     encoded;
    logic             busy;
    logic             ready;
    logic [4:0][63:0] y_out;
    logic             x_sign;
    logic             noncanon;
    logic             err;

    int checks = 0;
    int errors = 0;

    fe_decode dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .encoded  (encoded),
        .busy     (busy),
        .ready    (ready),
        .y_out    (y_out),
        .x_sign   (x_sign),
        .noncanon (noncanon),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: full-width compare against p, then split into limbs
    function automatic logic [4:0][63:0] model_y(input logic [255:0] v);
        logic [254:0]     x;
        logic [4:0][63:0] r;
        x = v[254:0];
        if (x >= P) begin
`ifdef FE_DECODE_STRICT_EN
            x = '0;
`else
            x = x - P;
`endif
        end
        for (int i = 0; i < 5; i++) r[i] = {13'd0, x[51*i +: 51]};
        return r;
    endfunction

    // Pulse start for one cycle, then time the ready pulse (bounded wait)
    task automatic run(input string tag, input logic [255:0] v);
        int n;
        @(negedge clk);
        encoded = v;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check({tag, "_busy_after_accept"}, 320'(busy), 320'(1'b1));
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 320'(n), 320'(8));
        check({tag, "_busy_at_ready"}, 320'(busy), 320'(1'b0));
        $display("decode %s: encoded=%h ready_cycle=%0d y=%h x_sign=%0b noncanon=%0b err=%0b",
                 tag, v, n, y_out, x_sign, noncanon, err);
    endtask

    task automatic check_ready_drops(input string tag);
        @(posedge clk); #1;
        check({tag, "_ready_pulse"}, 320'(ready), 320'(1'b0));
    endtask

    initial begin
        logic [255:0]     vals [27];
        logic [255:0]     v;
        logic [4:0][63:0] exp_y;
        int               rcount;
        int               idx;
        logic             exp_ready;

        rst_n   = 1'b0;
        start   = 1'b0;
        encoded = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy",     320'(busy),     320'(1'b0));
        check("reset_ready",    320'(ready),    320'(1'b0));
        check("reset_y",        320'(y_out),    320'(0));
        check("reset_x_sign",   320'(x_sign),   320'(1'b0));
        check("reset_noncanon", 320'(noncanon), 320'(1'b0));
        check("reset_err",      320'(err),      320'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Zero encoding
        run("zero", 256'd0);
        check("zero_y",        320'(y_out),    320'(0));
        check("zero_x_sign",   320'(x_sign),   320'(1'b0));
        check("zero_noncanon", 320'(noncanon), 320'(1'b0));
        check("zero_err",      320'(err),      320'(1'b0));
        check_ready_drops("zero");

        // p-1 with sign set: largest canonical value, passes through unchanged
        run("pm1", {1'b1, P - 255'd1});
        exp_y = {LIMB_ONES, LIMB_ONES, LIMB_ONES, LIMB_ONES, LIMB_PM1};
        check("pm1_y",        320'(y_out),    320'(exp_y));
        check("pm1_x_sign",   320'(x_sign),   320'(1'b1));
        check("pm1_noncanon", 320'(noncanon), 320'(1'b0));
        check("pm1_err",      320'(err),      320'(1'b0));
        check_ready_drops("pm1");

        // p itself: smallest non-canonical value, reduces to 0
        run("p", {1'b0, P});
        check("p_y",        320'(y_out),    320'(0));
        check("p_x_sign",   320'(x_sign),   320'(1'b0));
        check("p_noncanon", 320'(noncanon), 320'(1'b1));
        check("p_err",      320'(err),      320'(EXP_ERR_NC));
        check_ready_drops("p");

        // 2^255-1 with sign: largest non-canonical value, reduces to 18
        run("max", {1'b1, {255{1'b1}}});
        exp_y = {64'd0, 64'd0, 64'd0, 64'd0, EXP_Y0_MAX};
        check("max_y",        320'(y_out),    320'(exp_y));
        check("max_x_sign",   320'(x_sign),   320'(1'b1));
        check("max_noncanon", 320'(noncanon), 320'(1'b1));
        check("max_err",      320'(err),      320'(EXP_ERR_NC));
        check_ready_drops("max");

        // Start held high with a new value every cycle: accepts at 0, 9, 18
        for (int c = 0; c < 27; c++) begin
            vals[c] = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
        end
        vals[9] = {1'b0, P + 255'd14};
        rcount = 0;
        for (int c = 0; c < 27; c++) begin
            @(negedge clk);
            encoded = vals[c];
            start   = 1'b1;
            @(posedge clk); #1;
            exp_ready = (c + 1 == 8) || (c + 1 == 17) || (c + 1 == 26);
            check($sformatf("stream_ready_c%0d", c + 1), 320'(ready), 320'(exp_ready));
            if (ready && c + 1 >= 8) begin
                rcount++;
                idx = c + 1 - 8;
                v   = vals[idx];
                check($sformatf("stream_y_idx%0d", idx), 320'(y_out), 320'(model_y(v)));
                check($sformatf("stream_x_sign_idx%0d", idx), 320'(x_sign), 320'(v[255]));
                check($sformatf("stream_noncanon_idx%0d", idx), 320'(noncanon), 320'(v[254:0] >= P));
                $display("stream cycle %0d: accepted idx %0d encoded=%h y=%h noncanon=%0b",
                         c + 1, idx, v, y_out, noncanon);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("stream_ready_count", 320'(rcount), 320'(3));
        repeat (3) @(posedge clk);

        // Load nonzero outputs, then reset at cycle 4 of the next decode
        run("pre_rst", {1'b1, {255{1'b1}}});
        @(negedge clk);
        encoded = {1'b1, P - 255'd1};
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_busy",     320'(busy),     320'(1'b0));
        check("rst_ready",    320'(ready),    320'(1'b0));
        check("rst_y",        320'(y_out),    320'(0));
        check("rst_x_sign",   320'(x_sign),   320'(1'b0));
        check("rst_noncanon", 320'(noncanon), 320'(1'b0));
        check("rst_err",      320'(err),      320'(1'b0));
        @(negedge clk);
        rst_n  = 1'b1;
        rcount = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ready) rcount++;
        end
        check("rst_no_ready", 320'(rcount), 320'(0));
        $display("reset at cycle 4: outputs cleared, ready pulses afterwards=%0d", rcount);

        // Decode after reset
        v = {1'b0, 255'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1111_2222_3333_4444_5555_6666_7777};
        run("post_rst", v);
        check("post_rst_y",        320'(y_out),    320'(model_y(v)));
        check("post_rst_x_sign",   320'(x_sign),   320'(1'b0));
        check("post_rst_noncanon", 320'(noncanon), 320'(1'b0));
        check("post_rst_err",      320'(err),      320'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
